// File: rtl/ahb_slave_port_arbiter_pkg.sv
// Shared AHB types for the slave-port arbiter: HTRANS codes, arbiter FSM states
// and the interconnect-wide master count.
package ahb_slave_port_arbiter_pkg;

  localparam int NO_OF_MASTERS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN,
    ARB_LOCK
  } arb_state_t;

  // NONSEQ and SEQ are the only codes that carry a real transfer.
  function automatic logic is_active(input htrans_e t);
    return t[1];
  endfunction

endpackage

// File: rtl/ahb_slave_port_arbiter_rr_picker.sv
// Round-robin picker: scans ptr+1 .. ptr+N (mod N) over req and returns the
// first hit as one-hot grant, binary idx and a found flag. Purely combinational.
module ahb_rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    grant[idx] = found;
  end

endmodule

// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave AHB ownership controller: round-robin, burst- and lock-aware grant
// (grant_o/owner_id_o/owner_valid_o/hsel_o) plus data-phase owner tracking.
module ahb_slave_port_arbiter
  import ahb_slave_port_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS    = NO_OF_MASTERS,
  parameter  int MAX_HOLD_BEATS = 16,
  localparam int MIDW           = $clog2(NUM_MASTERS)
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic [NUM_MASTERS-1:0]   req_i,
  input  logic [2*NUM_MASTERS-1:0] htrans_i,
  input  logic [NUM_MASTERS-1:0]   hmastlock_i,
  input  logic                     hready_i,
  output logic [NUM_MASTERS-1:0]   grant_o,
  output logic [MIDW-1:0]          owner_id_o,
  output logic                     owner_valid_o,
  output logic                     hsel_o,
  output logic [MIDW-1:0]          dphase_id_o,
  output logic                     dphase_valid_o
);

  localparam int HW = $clog2(MAX_HOLD_BEATS + 1);
  localparam logic [MIDW-1:0] PTR_RST = MIDW'(NUM_MASTERS - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD_BEATS);

  arb_state_t state;
  logic [MIDW-1:0] rr_ptr;
  logic [HW-1:0] hold_cnt;

  logic [NUM_MASTERS-1:0] win;
  logic [MIDW-1:0] win_id;
  logic found;

  htrans_e own_tr;
  logic own_req;
  logic own_lock;
  logic others_req;
  logic hold_sat;
  logic rearb;

  ahb_rr_picker #(
    .N(NUM_MASTERS)
  ) u_picker (
    .req  (req_i),
    .ptr  (rr_ptr),
    .grant(win),
    .idx  (win_id),
    .found(found)
  );

  always_comb begin
    own_tr   = IDLE;
    own_req  = 1'b0;
    own_lock = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (owner_id_o == MIDW'(m)) begin
        own_tr   = htrans_e'(htrans_i[2*m +: 2]);
        own_req  = req_i[m];
        own_lock = hmastlock_i[m];
      end
    end
  end

  assign hsel_o     = owner_valid_o && is_active(own_tr);
  assign others_req = |(req_i & ~grant_o);
  assign hold_sat   = (hold_cnt >= HOLD_MAX);

  // Handover points: never inside a burst (SEQ/BUSY) and never while locked.
  always_comb begin
    rearb = 1'b0;
    unique case (1'b1)
      state == ARB_IDLE:
        rearb = 1'b1;
      state == ARB_OWN:
        rearb = !own_lock &&
                (own_tr == IDLE ||
                 (own_tr == NONSEQ &&
                  (!own_req || (hold_sat && others_req))));
      state == ARB_LOCK:
        rearb = !own_lock && own_tr == IDLE;
      default:
        rearb = 1'b0;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state          <= ARB_IDLE;
      rr_ptr         <= PTR_RST;
      hold_cnt       <= '0;
      grant_o        <= '0;
      owner_id_o     <= '0;
      owner_valid_o  <= 1'b0;
      dphase_id_o    <= '0;
      dphase_valid_o <= 1'b0;
    end else if (hready_i) begin
      dphase_valid_o <= hsel_o;
      if (hsel_o) dphase_id_o <= owner_id_o;
      if (rearb) begin
        hold_cnt <= '0;
        if (found) begin
          grant_o       <= win;
          owner_id_o    <= win_id;
          owner_valid_o <= 1'b1;
          rr_ptr        <= win_id;
          state         <= hmastlock_i[win_id] ? ARB_LOCK : ARB_OWN;
        end else begin
          grant_o       <= '0;
          owner_valid_o <= 1'b0;
          state         <= ARB_IDLE;
        end
      end else begin
        if (hsel_o && !hold_sat) hold_cnt <= hold_cnt + HW'(1);
        if (state == ARB_OWN && own_lock) state <= ARB_LOCK;
      end
    end
  end

endmodule
